lcd_module_model: RTL and testbench

- Synthesizable responder for the HD44780-style character-LCD bus (lcd_data/lcd_rs/lcd_rw/lcd_en) driven by our LCD controller.
- Decodes instruction and data writes, maintains an 80-byte DDRAM image plus display/entry/function state, and exposes a synchronous read port.
- Used as the bus-level checker in controller and bridge benches, and for on-chip mirroring of LCD text (e.g. to a VGA overlay).

---
 rtl/lcd_pkg.sv | 64 ++++++
 rtl/lcd_ddram.sv | 35 +++
 rtl/lcd_module_model.sv | 190 +++++++++++++++++++
 tb/tb_lcd_module_model.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus model.
// Holds instruction opcode masks, the DDRAM geometry, the blank fill
// character, the captured-transfer payload and address helper functions.
package lcd_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned OFS_W      = 6;
  localparam int unsigned LINE_LEN   = 40;
  localparam int unsigned DDRAM_SIZE = 80;

  localparam logic [ADDR_W-1:0] LINE0_BASE = 7'h00;
  localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h40;
  localparam logic [ADDR_W-1:0] LINE0_LAST = 7'h27;
  localparam logic [ADDR_W-1:0] LINE1_LAST = 7'h67;

  localparam logic [DATA_W-1:0] BLANK_CHAR_DEF = 8'h20;

  // Instruction opcode masks: the highest set bit selects the instruction.
  localparam logic [DATA_W-1:0] OP_SET_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] OP_SET_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] OP_FUNC_SET  = 8'h20;
  localparam logic [DATA_W-1:0] OP_SHIFT     = 8'h10;
  localparam logic [DATA_W-1:0] OP_DISP_CTRL = 8'h08;
  localparam logic [DATA_W-1:0] OP_ENTRY     = 8'h04;
  localparam logic [DATA_W-1:0] OP_HOME      = 8'h02;
  localparam logic [DATA_W-1:0] OP_CLEAR     = 8'h01;

  // One captured bus transfer.
  typedef struct packed {
    logic              rs;
    logic              rw;
    logic [DATA_W-1:0] data;
  } lcd_xfer_t;

  // True when an LCD address falls inside one of the two 40-byte lines.
  function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
    return a[5:0] < 6'(LINE_LEN);
  endfunction

  // LCD address to linear DDRAM index.
  function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] a);
    return a[6] ? (7'(LINE_LEN) + 7'(a[5:0])) : 7'(a[5:0]);
  endfunction

  // Address counter step with line wrap.
  function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] a, input logic up);
    if (up) begin
      if (a == LINE0_LAST) return LINE1_BASE;
      if (a == LINE1_LAST) return LINE0_BASE;
      return a + 7'd1;
    end
    if (a == LINE0_BASE) return LINE1_LAST;
    if (a == LINE1_BASE) return LINE0_LAST;
    return a - 7'd1;
  endfunction

  // Display shift offset step, modulo the line length.
  function automatic logic [OFS_W-1:0] ofs_step(input logic [OFS_W-1:0] o, input logic up);
    if (up) return (o == 6'(LINE_LEN - 1)) ? 6'd0 : o + 6'd1;
    return (o == 6'd0) ? 6'(LINE_LEN - 1) : o - 6'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 DDRAM image with one write port (linear index) and one registered
// read port addressed in LCD address space.
// Ports: clock, reset (sync, high; clears only the read register),
//        we/wr_idx/wr_data write port, rd_addr/rd_data read port.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DDRAM_SIZE];

  // Storage is deliberately not reset; contents persist across reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Registered read returns pre-write data on a same-cycle collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (addr_mapped(rd_addr)) begin
      rd_data <= mem[addr_to_idx(rd_addr)];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/lcd_module_model.sv
// Bus-level responder for an HD44780-style character LCD.
// Captures lcd_en/lcd_data/lcd_rs/lcd_rw, executes a transfer on the falling
// edge of enable, and keeps DDRAM plus display/entry/function state.
// Ports: clock, reset (sync, high); LCD bus inputs; rd_addr/rd_data read port;
//        ac, shift_ofs and control bits; busy, wr_strobe, overrun, addr_err.
module lcd_module_model
  import lcd_pkg::*;
#(
  parameter int unsigned       CLEAR_CYCLES = 80,
  parameter logic [DATA_W-1:0] BLANK_CHAR   = BLANK_CHAR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] lcd_data,
  input  logic              lcd_rs,
  input  logic              lcd_rw,
  input  logic              lcd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ac,
  output logic [OFS_W-1:0]  shift_ofs,
  output logic              display_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              inc_mode,
  output logic              shift_mode,
  output logic              two_line,
  output logic              font_5x10,
  output logic              bus_8bit,
  output logic              busy,
  output logic              wr_strobe,
  output logic              overrun,
  output logic              addr_err
);

  localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FILL = CNT_W'(DDRAM_SIZE);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state, state_nxt;
  logic              en_d, en_dd, rs_d, rw_d;
  logic [DATA_W-1:0] data_d;
  lcd_xfer_t         xfer;
  logic [CNT_W-1:0]  clr_cnt;

  logic              evt_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_idx_c;
  logic [DATA_W-1:0] ram_wdata_c;

  // Bus sampling; xfer holds the bus as seen on the last cycle en_d was high.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_d   <= 1'b0;
      en_dd  <= 1'b0;
      rs_d   <= 1'b0;
      rw_d   <= 1'b0;
      data_d <= '0;
      xfer   <= '0;
    end else begin
      en_d   <= lcd_en;
      en_dd  <= en_d;
      rs_d   <= lcd_rs;
      rw_d   <= lcd_rw;
      data_d <= lcd_data;
      if (en_d) xfer <= '{rs: rs_d, rw: rw_d, data: data_d};
    end
  end

  // Falling enable completes a transfer; reads are not modelled.
  assign evt_c = en_dd & ~en_d & ~xfer.rw;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and DDRAM write port.
  always_comb begin
    state_nxt   = state;
    ram_we_c    = 1'b0;
    ram_idx_c   = addr_to_idx(ac);
    ram_wdata_c = xfer.data;
    case (state)
      ST_IDLE: begin
        if (evt_c && xfer.rs) begin
          ram_we_c = 1'b1;
        end else if (evt_c && (xfer.data == OP_CLEAR)) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt < CNT_FILL) begin
          ram_we_c    = 1'b1;
          ram_idx_c   = ADDR_W'(clr_cnt);
          ram_wdata_c = BLANK_CHAR;
        end
        if (clr_cnt == CNT_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction/data execution and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ac         <= '0;
      shift_ofs  <= '0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc_mode   <= 1'b1;
      shift_mode <= 1'b0;
      two_line   <= 1'b0;
      font_5x10  <= 1'b0;
      bus_8bit   <= 1'b1;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      overrun    <= 1'b0;
      addr_err   <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (state == ST_CLEAR) begin
        if (evt_c) overrun <= 1'b1;
        clr_cnt <= clr_cnt + CNT_W'(1);
        if (clr_cnt == CNT_LAST) begin
          busy      <= 1'b0;
          ac        <= LINE0_BASE;
          shift_ofs <= '0;
          inc_mode  <= 1'b1;
        end
      end else if (evt_c && xfer.rs) begin
        wr_strobe <= 1'b1;
        ac        <= ac_step(ac, inc_mode);
        if (shift_mode) shift_ofs <= ofs_step(shift_ofs, inc_mode);
      end else if (evt_c) begin
        casez (xfer.data)
          8'b1???????: begin
            if (addr_mapped(xfer.data[6:0])) ac <= xfer.data[6:0];
            else                             addr_err <= 1'b1;
          end
          8'b01??????: ;
          8'b001?????: begin
            bus_8bit  <= xfer.data[4];
            two_line  <= xfer.data[3];
            font_5x10 <= xfer.data[2];
          end
          8'b0001????: begin
            if (xfer.data[3]) shift_ofs <= ofs_step(shift_ofs, xfer.data[2]);
            else              ac        <= ac_step(ac, xfer.data[2]);
          end
          8'b00001???: begin
            display_on <= xfer.data[2];
            cursor_on  <= xfer.data[1];
            blink_on   <= xfer.data[0];
          end
          8'b000001??: begin
            inc_mode   <= xfer.data[1];
            shift_mode <= xfer.data[0];
          end
          8'b0000001?: begin
            ac        <= LINE0_BASE;
            shift_ofs <= '0;
          end
          8'b00000001: begin
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  lcd_ddram u_ddram (
    .clock   (clock),
    .reset   (reset),
    .we      (ram_we_c),
    .wr_idx  (ram_idx_c),
    .wr_data (ram_wdata_c),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_lcd_module_model.sv
// Self-checking bench for lcd_module_model: drives LCD bus transfers,
// queues expected DDRAM read data and checks status outputs.
module tb_lcd_module_model;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_data = '0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic [5:0] shift_ofs;
  logic       display_on, cursor_on, blink_on, inc_mode, shift_mode;
  logic       two_line, font_5x10, bus_8bit, busy, wr_strobe, overrun, addr_err;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;
  logic [7:0] exp_q[$];
  logic [6:0] addr_q[$];

  lcd_module_model dut (
    .clock(clock), .reset(reset), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ac(ac), .shift_ofs(shift_ofs), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode),
    .shift_mode(shift_mode), .two_line(two_line), .font_5x10(font_5x10),
    .bus_8bit(bus_8bit), .busy(busy), .wr_strobe(wr_strobe),
    .overrun(overrun), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read scoreboard: pop the expected byte one cycle after the request.
  always @(posedge clock) rd_req_d <= rd_req;
  always @(negedge clock) begin
    if (wr_strobe) strobe_cnt++;
    if (rd_req_d) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        logic [6:0] a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rd_%02h", a), 32'(rd_data), 32'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clock); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    idle(2);
    lcd_en = 1'b0;
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d);
    send(rs, 1'b0, d);
    idle(4);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] e);
    @(posedge clock); #1;
    rd_addr = a; rd_req = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(posedge clock); #1;
    rd_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_busy_high(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clock);
      if (busy) break;
    end
    if (i == lim) check("busy_rise_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    if (i == lim) check("busy_fall_timeout", 32'd1, 32'd0);
    idle(2);
  endtask

  initial begin
    int cnt;
    int s0;

    idle(3);
    @(negedge clock);
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_inc_mode", 32'(inc_mode), 32'd1);
    check("rst_bus_8bit", 32'(bus_8bit), 32'd1);
    check("rst_flags", 32'({busy, overrun, addr_err, display_on, two_line, wr_strobe}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Init sequence.
    xfer(1'b0, 8'h38);
    xfer(1'b0, 8'h0C);
    check("init_two_line", 32'(two_line), 32'd1);
    check("init_display_on", 32'(display_on), 32'd1);
    check("init_cursor_on", 32'(cursor_on), 32'd0);
    send(1'b0, 1'b0, 8'h01);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check("clear_busy_len", 32'(cnt), 32'd80);
    xfer(1'b0, 8'h06);
    xfer(1'b0, 8'h80);
    check("init_ac", 32'(ac), 32'h0);
    for (int i = 0; i < 40; i++) begin
      rd(7'(i), 8'h20);
      rd(7'(8'h40 + i), 8'h20);
    end
    rd(7'h30, 8'h00);

    // Read-only transfer must be ignored.
    send(1'b0, 1'b1, 8'h01);
    idle(4);
    check("rw_ignored_busy", 32'(busy), 32'd0);

    // Text write across the line boundary.
    s0 = strobe_cnt;
    xfer(1'b0, 8'hA6);
    check("text_set_ac", 32'(ac), 32'h26);
    xfer(1'b1, 8'h57);
    xfer(1'b1, 8'h65);
    xfer(1'b1, 8'h6C);
    check("text_ac", 32'(ac), 32'h41);
    check("text_strobes", 32'(strobe_cnt - s0), 32'd3);
    rd(7'h26, 8'h57);
    rd(7'h27, 8'h65);
    rd(7'h40, 8'h6C);

    // Decrement wraps.
    xfer(1'b0, 8'h04);
    xfer(1'b0, 8'h80);
    xfer(1'b1, 8'h41);
    check("dec_wrap0_ac", 32'(ac), 32'h67);
    xfer(1'b0, 8'hC0);
    xfer(1'b1, 8'h42);
    check("dec_wrap1_ac", 32'(ac), 32'h27);
    rd(7'h00, 8'h41);
    rd(7'h40, 8'h42);

    // Transfer during clear is dropped and flagged.
    check("pre_overrun", 32'(overrun), 32'd0);
    send(1'b0, 1'b0, 8'h01);
    wait_busy_high(20);
    repeat (8) @(negedge clock);
    send(1'b1, 1'b0, 8'h58);
    wait_idle(200);
    check("overrun_set", 32'(overrun), 32'd1);
    check("clear_ac", 32'(ac), 32'h0);
    check("clear_inc_mode", 32'(inc_mode), 32'd1);
    rd(7'h00, 8'h20);
    rd(7'h40, 8'h20);

    // Unmapped set-DDRAM and display shift left.
    xfer(1'b0, 8'hB0);
    check("addr_err_set", 32'(addr_err), 32'd1);
    check("addr_err_ac", 32'(ac), 32'h0);
    xfer(1'b0, 8'h18);
    check("shift_left_wrap", 32'(shift_ofs), 32'd39);
    xfer(1'b0, 8'h14);
    check("cursor_right", 32'(ac), 32'h01);

    // Reset mid-clear preserves uncleared text.
    xfer(1'b0, 8'hC5);
    xfer(1'b1, 8'h54);
    xfer(1'b0, 8'hA0);
    xfer(1'b1, 8'h55);
    send(1'b0, 1'b0, 8'h01);
    wait_busy_high(20);
    repeat (19) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_flags", 32'({overrun, addr_err}), 32'd0);
    check("rst_mid_ofs", 32'(shift_ofs), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    rd(7'h45, 8'h54);
    rd(7'h20, 8'h55);
    rd(7'h00, 8'h20);

    idle(3);
    check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
